x7seg_monitor: RTL and testbench

Reconstructs hex digits from a multiplexed, active-low seven-segment bus (`a_to_g`, `an`) as driven by the display driver. Filters scan glitches, decodes each stable digit, and presents a complete display word with a one-cycle frame strobe. Sits beside the display driver in benches and on-board self-check logic, closing the loop on what the display actually shows.

---
 rtl/x7seg_pkg.sv | 30 +++
 rtl/x7seg_glyph_dec.sv | 33 +++
 rtl/x7seg_monitor.sv | 145 ++++++++++++++
 tb/tb_x7seg_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x7seg_pkg.sv
// Shared constants for the seven-segment monitor: active-low glyph patterns (bit 6 = a .. bit 0 = g),
// the default stability depth and the decoded-glyph record.
package x7seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int STABLE_CYCLES_DEF = 4;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } glyph_t;

endpackage

// File: rtl/x7seg_glyph_dec.sv
// Combinational segment-pattern to hex-nibble decoder; vld stays low for any pattern
// that is not one of the sixteen hex glyphs (blank included).
module x7seg_glyph_dec
  import x7seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output glyph_t     o_glyph
);

  always_comb begin
    o_glyph = '{vld: 1'b0, nib: 4'h0};
    case (i_seg)
      SEG_0:   o_glyph = '{vld: 1'b1, nib: 4'h0};
      SEG_1:   o_glyph = '{vld: 1'b1, nib: 4'h1};
      SEG_2:   o_glyph = '{vld: 1'b1, nib: 4'h2};
      SEG_3:   o_glyph = '{vld: 1'b1, nib: 4'h3};
      SEG_4:   o_glyph = '{vld: 1'b1, nib: 4'h4};
      SEG_5:   o_glyph = '{vld: 1'b1, nib: 4'h5};
      SEG_6:   o_glyph = '{vld: 1'b1, nib: 4'h6};
      SEG_7:   o_glyph = '{vld: 1'b1, nib: 4'h7};
      SEG_8:   o_glyph = '{vld: 1'b1, nib: 4'h8};
      SEG_9:   o_glyph = '{vld: 1'b1, nib: 4'h9};
      SEG_A:   o_glyph = '{vld: 1'b1, nib: 4'hA};
      SEG_B:   o_glyph = '{vld: 1'b1, nib: 4'hB};
      SEG_C:   o_glyph = '{vld: 1'b1, nib: 4'hC};
      SEG_D:   o_glyph = '{vld: 1'b1, nib: 4'hD};
      SEG_E:   o_glyph = '{vld: 1'b1, nib: 4'hE};
      SEG_F:   o_glyph = '{vld: 1'b1, nib: 4'hF};
      default: o_glyph = '{vld: 1'b0, nib: 4'h0};
    endcase
  end

endmodule

// File: rtl/x7seg_monitor.sv
// Rebuilds the displayed hex word from a multiplexed active-low segment bus, with glitch filtering,
// sticky error flag and a one-cycle frame strobe. X7SEG_MONITOR_DP_EN adds decimal-point capture.
module x7seg_monitor
  import x7seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [6:0]            i_a_to_g,
  input  logic [DIGITS-1:0]     i_an,
`ifdef X7SEG_MONITOR_DP_EN
  input  logic                  i_dp,
  output logic [DIGITS-1:0]     o_dp_out,
`endif
  output logic [4*DIGITS-1:0]   o_x,
  output logic                  o_frame_valid,
  output logic                  o_err
);

`ifdef X7SEG_MONITOR_DP_EN
  localparam int SW = 8 + DIGITS;
`else
  localparam int SW = 7 + DIGITS;
`endif
  localparam int              CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ARM = CW'(STABLE_CYCLES - 2);

  logic [SW-1:0]         w_sample;
  logic [SW-1:0]         r_s;
  logic [SW-1:0]         r_p;
  logic [CW-1:0]         r_cnt;
  logic [6:0]            w_seg;
  logic [DIGITS-1:0]     w_sel;
  logic                  w_same;
  logic                  w_cap;
  logic                  w_multi;
  logic                  w_one;
  logic                  w_wr;
  logic                  w_full;
  glyph_t                w_glyph;
  logic [4*DIGITS-1:0]   r_slots;
  logic [4*DIGITS-1:0]   w_slots_nxt;
  logic [4*DIGITS-1:0]   r_x;
  logic [DIGITS-1:0]     r_seen;
  logic [DIGITS-1:0]     w_seen_nxt;
  logic                  r_fv;
  logic                  r_err;

`ifdef X7SEG_MONITOR_DP_EN
  assign w_sample = {i_dp, i_a_to_g, i_an};
`else
  assign w_sample = {i_a_to_g, i_an};
`endif

  assign w_seg = r_s[DIGITS +: 7];
  assign w_sel = ~r_s[DIGITS-1:0];

  // Capture fires once, on the sample that lifts the counter onto its saturation value.
  assign w_same  = (r_s == r_p);
  assign w_cap   = w_same && (r_cnt == CNT_ARM);
  assign w_multi = |(w_sel & (w_sel - DIGITS'(1)));
  assign w_one   = (w_sel != '0) && !w_multi;
  assign w_wr    = w_cap && w_one && w_glyph.vld;

  x7seg_glyph_dec u_dec (
    .i_seg   (w_seg),
    .o_glyph (w_glyph)
  );

  always_comb begin
    w_slots_nxt = r_slots;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_slots_nxt[4*i +: 4] = w_glyph.nib;
    end
  end

  assign w_seen_nxt = r_seen | w_sel;
  assign w_full     = &w_seen_nxt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_s     <= '1;
      r_p     <= '1;
      r_cnt   <= '0;
      r_seen  <= '0;
      r_slots <= '0;
      r_x     <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_s  <= w_sample;
      r_p  <= r_s;
      r_fv <= 1'b0;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap && (w_multi || (w_one && !w_glyph.vld))) r_err <= 1'b1;
      if (w_wr) begin
        r_slots <= w_slots_nxt;
        if (w_full) begin
          r_x    <= w_slots_nxt;
          r_fv   <= 1'b1;
          r_seen <= '0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

`ifdef X7SEG_MONITOR_DP_EN
  logic [DIGITS-1:0] r_dp_slots;
  logic [DIGITS-1:0] w_dp_nxt;
  logic [DIGITS-1:0] r_dp_x;

  always_comb begin
    w_dp_nxt = r_dp_slots;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_dp_nxt[i] = r_s[SW-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_dp_slots <= '0;
      r_dp_x     <= '0;
    end else if (w_wr) begin
      r_dp_slots <= w_dp_nxt;
      if (w_full) r_dp_x <= w_dp_nxt;
    end
  end

  assign o_dp_out = r_dp_x;
`endif

  assign o_x           = r_x;
  assign o_frame_valid = r_fv;
  assign o_err         = r_err;

endmodule

// File: tb/tb_x7seg_monitor.sv
// Bench for x7seg_monitor: directed scans plus random bus activity, checked every cycle
// against a run-length based model of the display bus.
module tb_x7seg_monitor;

  localparam int D = 4;
  localparam int S = 4;
  localparam logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        clr;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic [15:0] x;
  logic        fv;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fv   = 0;
  bit chk_en = 1'b0;

  x7seg_monitor #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .i_clk         (clk),
    .i_clr         (clr),
    .i_a_to_g      (a_to_g),
    .i_an          (an),
    .o_x           (x),
    .o_frame_valid (fv),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  m_lseg;
  logic [3:0]  m_lan;
  int          m_run;
  bit          m_pend;
  logic [6:0]  m_pseg;
  logic [3:0]  m_pan;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [15:0] m_x;
  bit          m_fv;
  bit          m_err;

  function automatic int glyph_index(input logic [6:0] s);
    for (int g = 0; g < 16; g++) if (GLY[g] == s) return g;
    return -1;
  endfunction

  task automatic model_capture(input logic [6:0] seg, input logic [3:0] a);
    int zeros;
    int d;
    int g;
    zeros = $countones(~a);
    d = 0;
    if (zeros > 1) begin
      m_err = 1'b1;
    end else if (zeros == 1) begin
      for (int k = 0; k < 4; k++) if (!a[k]) d = k;
      g = glyph_index(seg);
      if (g < 0) begin
        m_err = 1'b1;
      end else begin
        m_slot[d] = g[3:0];
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          m_x    = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
          m_fv   = 1'b1;
          m_seen = 4'h0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
      m_seen = 4'h0;
      m_x    = 16'h0;
      m_fv   = 1'b0;
      m_err  = 1'b0;
      m_lseg = 7'h7F;
      m_lan  = 4'hF;
      m_run  = 2;
      m_pend = 1'b0;
    end else begin
      m_fv = 1'b0;
      if (m_pend) model_capture(m_pseg, m_pan);
      if (a_to_g == m_lseg && an == m_lan) begin
        if (m_run <= S) m_run++;
      end else begin
        m_run  = 1;
        m_lseg = a_to_g;
        m_lan  = an;
      end
      m_pend = (m_run == S);
      m_pseg = a_to_g;
      m_pan  = an;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("x", x, m_x);
      check("frame_valid", fv, m_fv);
      check("err", err, m_err);
      if (fv === 1'b1) n_fv++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [6:0] s, input logic [3:0] a, input int n);
    a_to_g = s;
    an     = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [3:0] nib, input int n);
    step(GLY[nib], ~(4'b0001 << d), n);
  endtask

  task automatic scan(input logic [15:0] w, input int n);
    for (int d = 0; d < 4; d++) show(d, w[4*d +: 4], n);
  endtask

  task automatic clr_pulse(input int n);
    clr = 1'b1;
    @(negedge clk);
    #1;
    check("clr_x", x, 0);
    check("clr_fv", fv, 0);
    check("clr_err", err, 0);
    repeat (n - 1) @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [15:0] words [4];
    logic [15:0] w;
    int f0;
    int r;
    words = '{16'h1234, 16'hABCD, 16'hEF90, 16'h5678};

    clr    = 1'b1;
    a_to_g = 7'h7F;
    an     = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_fv", fv, 0);
    check("rst_err", err, 0);
    clr = 1'b0;

    for (int k = 0; k < 2; k++) begin
      f0 = n_fv;
      scan(16'h000A, 8);
      #1;
      check("scan0A_x", x, 16'h000A);
      check("scan0A_model", m_x, 16'h000A);
      check("scan0A_fv_pulses", n_fv - f0, 1);
      check("scan0A_err", err, 0);
    end

    foreach (words[k]) begin
      scan(words[k], 8);
      #1;
      check("glyph_scan_x", x, words[k]);
    end

    // Two-cycle blank glitch on digit 2, flanked by runs long enough to capture
    show(0, 4'h1, 8);
    show(1, 4'h2, 8);
    show(2, 4'h3, 5);
    step(7'h7F, 4'b1011, 2);
    show(2, 4'h3, 5);
    show(3, 4'h4, 8);
    #1;
    check("glitch_x", x, 16'h4321);
    check("glitch_err", err, 0);

    step(GLY[8], 4'b1100, 8);
    #1;
    check("multi_an_err", err, 1);
    scan(16'h2468, 8);
    #1;
    check("sticky_err", err, 1);
    check("sticky_x", x, 16'h2468);
    clr_pulse(2);

    f0 = n_fv;
    show(0, 4'h1, 8);
    step(7'b1110111, 4'b1101, 8);
    show(2, 4'h7, 8);
    show(3, 4'hC, 8);
    #1;
    check("bad_glyph_no_frame", n_fv - f0, 0);
    check("bad_glyph_err", err, 1);
    show(1, 4'h9, 8);
    #1;
    check("bad_glyph_recover_fv", n_fv - f0, 1);
    check("bad_glyph_recover_x", x, 16'hC791);
    clr_pulse(1);

    show(0, 4'hD, 8);
    show(1, 4'h0, 8);
    show(2, 4'h0, 8);
    clr_pulse(2);
    f0 = n_fv;
    show(3, 4'hF, 8);
    #1;
    check("clr_partial_no_frame", n_fv - f0, 0);
    scan(16'hF00D, 8);
    #1;
    check("clr_partial_fv", n_fv - f0, 1);
    check("clr_partial_x", x, 16'hF00D);

    for (int k = 0; k < 2500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        show($urandom_range(0, 3), 4'($urandom_range(0, 15)), $urandom_range(1, 8));
      end else if (r < 80) begin
        step(7'($urandom_range(0, 127)), ~(4'b0001 << $urandom_range(0, 3)), $urandom_range(1, 5));
      end else if (r < 86) begin
        step(GLY[$urandom_range(0, 15)], 4'($urandom_range(0, 15)), $urandom_range(1, 6));
      end else if (r < 91) begin
        step(7'h7F, 4'hF, $urandom_range(1, 4));
      end else if (r < 94) begin
        clr_pulse($urandom_range(1, 2));
      end else begin
        w = 16'($urandom);
        scan(w, $urandom_range(4, 8));
      end
    end

    step(7'h7F, 4'hF, 4);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
